// File: rtl/fetch_pkg.sv
// Shared constants and types for the instruction fetch stage.
package fetch_pkg;

   localparam int unsigned INSTR_WIDTH = 32;
   localparam int unsigned PC_STEP     = 4;
   localparam logic [INSTR_WIDTH-1:0] NOP_INSTR = 32'h00000013;

   typedef enum logic [0:0] {
      FETCH,
      DRAIN
   } fetch_state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO holding {pc, instruction} pairs for the decode stage.
// Flush clears the FIFO and wins over a push in the same cycle.
module fetch_fifo #(
   parameter int unsigned WIDTH = 96,
   parameter int unsigned DEPTH = 4,
   localparam int unsigned CW   = $clog2(DEPTH) + 1
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             flush_i,
   input  logic             push_i,
   input  logic [WIDTH-1:0] wdata_i,
   input  logic             pop_i,
   output logic [WIDTH-1:0] rdata_o,
   output logic [CW-1:0]    count_o,
   output logic             empty_o,
   output logic             full_o
);

   localparam int unsigned PW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic             do_push;
   logic             do_pop;

   assign empty_o = (count_q == '0);
   assign full_o  = (count_q == CW'(DEPTH));
   assign do_pop  = pop_i && !empty_o;
   // A pop frees the slot at the same edge, so push-while-full is allowed with a pop.
   assign do_push = push_i && (!full_o || do_pop);
   assign rdata_o = mem_q[rd_ptr_q];
   assign count_o = count_q;

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_q + CW'(do_push) - CW'(do_pop);
      end
   end

   // Storage write; contents need no reset since count gates visibility.
   always_ff @(posedge clk_i) begin
      if (do_push && !flush_i && !rst_i) mem_q[wr_ptr_q] <= wdata_i;
   end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Prefetching fetch stage: issues word-aligned requests, buffers in-order responses
// with their PCs and hands them to decode. Redirects flush and drain stale responses.
module instruction_fetch_unit
   import fetch_pkg::*;
#(
   parameter int unsigned            ADDR_WIDTH = 64,
   parameter int unsigned            DEPTH      = 4,
   parameter logic [ADDR_WIDTH-1:0]  RESET_PC   = '0
) (
   input  logic                   clock,
   input  logic                   reset,
   output logic                   mem_req_valid,
   input  logic                   mem_req_ready,
   output logic [ADDR_WIDTH-1:0]  mem_req_addr,
   input  logic                   mem_resp_valid,
   input  logic [INSTR_WIDTH-1:0] mem_resp_data,
   output logic                   instr_valid,
   input  logic                   instr_ready,
   output logic [INSTR_WIDTH-1:0] instruction,
   output logic [ADDR_WIDTH-1:0]  instr_pc,
   input  logic                   redirect,
   input  logic [ADDR_WIDTH-1:0]  redirect_pc
);

   localparam int unsigned CW = $clog2(DEPTH) + 1;
   localparam int unsigned EW = ADDR_WIDTH + INSTR_WIDTH;

   fetch_state_t          state_q, state_d;
   logic [ADDR_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
   logic [ADDR_WIDTH-1:0] resp_pc_q, resp_pc_d;
   logic [CW-1:0]         outstanding_q, outstanding_d;
   logic [CW-1:0]         fifo_count;
   logic                  fifo_empty;
   logic                  fifo_full;
   logic [EW-1:0]         fifo_rdata;
   logic                  fifo_push;
   logic                  fifo_pop;
   logic                  req_fire;
   logic                  resp_take;
   logic                  credit_ok;
   logic [CW:0]           credits_used;
   logic [ADDR_WIDTH-1:0] redirect_pc_aligned;
   logic                  unused_redirect_lsbs;

   assign redirect_pc_aligned  = {redirect_pc[ADDR_WIDTH-1:2], 2'b00};
   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   // Every buffered or in-flight instruction holds a credit, so the FIFO cannot overflow.
   assign credits_used = {1'b0, outstanding_q} + {1'b0, fifo_count};
   assign credit_ok    = (credits_used < (CW + 1)'(DEPTH));

   assign mem_req_valid = (state_q == FETCH) && credit_ok && !redirect && !reset;
   assign mem_req_addr  = fetch_pc_q;
   assign req_fire      = mem_req_valid && mem_req_ready;

   // A response with nothing outstanding is a leftover from before a reset.
   assign resp_take     = mem_resp_valid && (outstanding_q != '0);
   assign fifo_push     = (state_q == FETCH) && resp_take && !redirect;
   assign outstanding_d = outstanding_q + CW'(req_fire) - CW'(resp_take);

   assign instr_valid   = !fifo_empty && !reset;
   assign fifo_pop      = instr_valid && instr_ready;
   assign instr_pc      = fifo_rdata[EW-1:INSTR_WIDTH];
   assign instruction   = fifo_empty ? NOP_INSTR : fifo_rdata[INSTR_WIDTH-1:0];

   fetch_fifo #(
      .WIDTH (EW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk_i   (clock),
      .rst_i   (reset),
      .flush_i (redirect),
      .push_i  (fifo_push),
      .wdata_i ({resp_pc_q, mem_resp_data}),
      .pop_i   (fifo_pop),
      .rdata_o (fifo_rdata),
      .count_o (fifo_count),
      .empty_o (fifo_empty),
      .full_o  (fifo_full)
   );

   // Next state and PC tracking; redirect overrides everything.
   always_comb begin
      state_d    = state_q;
      fetch_pc_d = fetch_pc_q;
      resp_pc_d  = resp_pc_q;
      if (req_fire)  fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(PC_STEP);
      if (fifo_push) resp_pc_d  = resp_pc_q + ADDR_WIDTH'(PC_STEP);
      unique case (state_q)
         FETCH:   state_d = FETCH;
         DRAIN:   if (outstanding_d == '0) state_d = FETCH;
         default: state_d = FETCH;
      endcase
      if (redirect) begin
         fetch_pc_d = redirect_pc_aligned;
         resp_pc_d  = redirect_pc_aligned;
         state_d    = (outstanding_d != '0) ? DRAIN : FETCH;
      end
   end

   // State, PC and outstanding-count registers.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_q       <= FETCH;
         fetch_pc_q    <= RESET_PC;
         resp_pc_q     <= RESET_PC;
         outstanding_q <= '0;
      end else begin
         state_q       <= state_d;
         fetch_pc_q    <= fetch_pc_d;
         resp_pc_q     <= resp_pc_d;
         outstanding_q <= outstanding_d;
      end
   end

   // Credit accounting must keep pushes away from a full FIFO unless it pops.
   assert property (@(posedge clock) disable iff (reset) !(fifo_push && fifo_full && !fifo_pop));

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Randomized bench for instruction_fetch_unit with an in-bench memory and a
// stream-level reference model (request/delivery PC sequences per epoch).
module tb_instruction_fetch_unit;

   localparam int unsigned AW    = 64;
   localparam int unsigned DEPTH = 4;
   localparam logic [63:0] RPC   = 64'h0;

   logic          clock = 1'b0;
   logic          reset;
   logic          mem_req_valid, mem_req_ready;
   logic [AW-1:0] mem_req_addr;
   logic          mem_resp_valid;
   logic [31:0]   mem_resp_data;
   logic          instr_valid, instr_ready;
   logic [31:0]   instruction;
   logic [AW-1:0] instr_pc;
   logic          redirect;
   logic [AW-1:0] redirect_pc;

   always #5 clock = ~clock;

   instruction_fetch_unit #(
      .ADDR_WIDTH (AW),
      .DEPTH      (DEPTH),
      .RESET_PC   (RPC)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .mem_req_valid  (mem_req_valid),
      .mem_req_ready  (mem_req_ready),
      .mem_req_addr   (mem_req_addr),
      .mem_resp_valid (mem_resp_valid),
      .mem_resp_data  (mem_resp_data),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instruction    (instruction),
      .instr_pc       (instr_pc),
      .redirect       (redirect),
      .redirect_pc    (redirect_pc)
   );

   typedef struct {
      logic [63:0] addr;
      int          due;
      bit          live;
   } mreq_t;

   mreq_t       mq[$];
   int          cyc, last_due, lat_min, lat_max;
   int          n_vec, n_err, n_fire;
   int          live_inflight, fifo_n;
   int          first_fire_cyc, first_valid_cyc;
   logic [63:0] exp_req_pc, exp_del_pc;
   logic [63:0] first_req_pc, first_del_pc;
   logic [31:0] first_instr;
   bit          first_req_seen, first_del_seen;

   function automatic logic [31:0] mem_word(input logic [63:0] a);
      return 32'h00500093 ^ {a[15:2], 18'h0} ^ a[47:16];
   endfunction

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   task automatic clear_marks();
      first_fire_cyc  = -1;
      first_valid_cyc = -1;
      first_req_seen  = 0;
      first_del_seen  = 0;
      n_fire          = 0;
   endtask

   // One clock: drive at posedge+1, check at posedge+2, update model, advance.
   task automatic step(input logic rdy, input logic irdy, input logic redir,
                       input logic [63:0] rpc, input logic rst, input logic stray);
      int   stale;
      int   lat;
      bit   got_resp, resp_live;
      logic fire, deliver;
      mem_req_ready = rdy;
      instr_ready   = irdy;
      redirect      = redir;
      redirect_pc   = rpc;
      reset         = rst;
      stale = 0;
      foreach (mq[i]) if (!mq[i].live) stale++;
      got_resp  = 0;
      resp_live = 0;
      if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
         mem_resp_valid = 1'b1;
         mem_resp_data  = mem_word(mq[0].addr);
         resp_live      = mq[0].live;
         got_resp       = 1;
         void'(mq.pop_front());
      end else if (stray) begin
         mem_resp_valid = 1'b1;
         mem_resp_data  = 32'hdeadbeef;
      end else begin
         mem_resp_valid = 1'b0;
         mem_resp_data  = $urandom;
      end
      #1;
      fire    = mem_req_valid && rdy;
      deliver = instr_valid && irdy;
      if (rst) begin
         check_eq("rst_req_valid", 64'(mem_req_valid), 64'd0);
         check_eq("rst_instr_valid", 64'(instr_valid), 64'd0);
      end else begin
         check_eq("req_valid", 64'(mem_req_valid),
                  64'(!redir && stale == 0 && live_inflight < int'(DEPTH)));
         if (mem_req_valid) check_eq("req_addr", mem_req_addr, exp_req_pc);
         check_eq("instr_valid", 64'(instr_valid), 64'(fifo_n > 0));
         if (deliver) begin
            check_eq("instr_pc", instr_pc, exp_del_pc);
            check_eq("instruction", 64'(instruction), 64'(mem_word(exp_del_pc)));
            if (!first_del_seen) begin
               first_del_seen = 1;
               first_del_pc   = instr_pc;
               first_instr    = instruction;
            end
            exp_del_pc += 64'd4;
         end
         if (instr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      end
      if (rst) begin
         mq.delete();
         live_inflight = 0;
         fifo_n        = 0;
         exp_req_pc    = RPC;
         exp_del_pc    = RPC;
         last_due      = cyc;
      end else begin
         if (fire) begin
            lat = $urandom_range(lat_max, lat_min);
            last_due = (cyc + lat > last_due + 1) ? cyc + lat : last_due + 1;
            mq.push_back('{addr: mem_req_addr, due: last_due, live: 1'b1});
            if (!first_req_seen) begin
               first_req_seen = 1;
               first_req_pc   = mem_req_addr;
            end
            if (first_fire_cyc < 0) first_fire_cyc = cyc;
            n_fire++;
            exp_req_pc += 64'd4;
            live_inflight++;
         end
         if (deliver) begin
            live_inflight--;
            fifo_n--;
         end
         if (got_resp && resp_live) fifo_n++;
         if (redir) begin
            foreach (mq[i]) mq[i].live = 0;
            live_inflight = 0;
            fifo_n        = 0;
            exp_req_pc    = {rpc[63:2], 2'b00};
            exp_del_pc    = {rpc[63:2], 2'b00};
         end
      end
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic do_reset();
      step(1'b1, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
      step(1'b1, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
   endtask

   initial begin
      logic [63:0] held;
      n_vec = 0; n_err = 0; cyc = 0; last_due = 0;
      lat_min = 1; lat_max = 1;
      live_inflight = 0; fifo_n = 0;
      exp_req_pc = RPC; exp_del_pc = RPC;
      mem_req_ready = 0; instr_ready = 0; redirect = 0; redirect_pc = '0;
      mem_resp_valid = 0; mem_resp_data = '0; reset = 1;
      @(posedge clock);
      #1;

      // 1: straight-line fetch, 1-cycle memory, decode always ready.
      do_reset();
      clear_marks();
      for (int i = 0; i < 12; i++) step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
      check_eq("t1_latency", 64'(first_valid_cyc - first_fire_cyc), 64'd2);
      check_eq("t1_first_pc", first_del_pc, 64'h0);
      check_eq("t1_first_instr", 64'(first_instr), 64'h00500093);

      // 2: decode stalled -> exactly DEPTH requests, then drain the buffer.
      do_reset();
      clear_marks();
      for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      check_eq("t2_req_count", 64'(n_fire), 64'(DEPTH));
      check_eq("t2_req_valid_low", 64'(mem_req_valid), 64'd0);
      for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);

      // 3: 3-cycle memory, redirect with two requests in flight.
      lat_min = 3; lat_max = 3;
      do_reset();
      step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
      step(1'b0, 1'b1, 1'b1, 64'h103, 1'b0, 1'b0);
      clear_marks();
      for (int i = 0; i < 14; i++) step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
      check_eq("t3_first_req", first_req_pc, 64'h100);
      check_eq("t3_first_del", first_del_pc, 64'h100);

      // 4: redirect while a response lands and decode pops.
      lat_min = 1; lat_max = 1;
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 64'h2000, 1'b0, 1'b0);
      check_eq("t4_instr_valid_after", 64'(instr_valid), 64'd0);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);

      // 5: memory stalls for five cycles; request must hold.
      step(1'b0, 1'b0, 1'b1, 64'h4000, 1'b0, 1'b0);
      held = 64'h4000;
      for (int i = 0; i < 5; i++) begin
         step(1'b0, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
         check_eq("t5_hold_valid", 64'(mem_req_valid), 64'd1);
         check_eq("t5_hold_addr", mem_req_addr, held);
      end
      step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      check_eq("t5_next_addr", mem_req_addr, held + 64'd4);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);

      // 6: reset with buffered data and requests in flight; stray response after.
      lat_min = 3; lat_max = 3;
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 1'b0, 64'h0, 1'b0, 1'b0);
      step(1'b1, 1'b1, 1'b0, 64'h0, 1'b1, 1'b0);
      check_eq("t6_instr_valid", 64'(instr_valid), 64'd0);
      lat_min = 1; lat_max = 1;
      clear_marks();
      step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 1'b1);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b1, 1'b0, 64'h0, 1'b0, 1'b0);
      check_eq("t6_restart_pc", first_req_pc, RPC);
      check_eq("t6_first_del", first_del_pc, RPC);

      // Random traffic across latency ranges, including wrap-around redirects.
      for (int ph = 0; ph < 4; ph++) begin
         lat_min = 1;
         lat_max = 1 + ph;
         for (int i = 0; i < 500; i++) begin
            logic        r, d, rd, rs;
            logic [63:0] tgt;
            r   = ($urandom_range(99, 0) < 70);
            d   = ($urandom_range(99, 0) < 70);
            rd  = ($urandom_range(99, 0) < 4);
            rs  = ($urandom_range(199, 0) == 0);
            tgt = {$urandom, $urandom};
            if ($urandom_range(3, 0) == 0) tgt = 64'hffff_ffff_ffff_fff3;
            step(r, d, rd, tgt, rs, 1'b0);
         end
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
